sub_32_bit_serial: RTL and testbench



---
 rtl/sub_serial_pkg.sv | 23 ++
 rtl/sub_digit_slice.sv | 18 +
 rtl/sub_32_bit_serial.sv | 125 ++++++++++++
 tb/tb_sub_32_bit_serial.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_serial_pkg;

    // Operation sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 32;

    // Number of digit steps needed to cover the full operand width
    function automatic int calc_steps(input int width, input int digit_w);
        return width / digit_w;
    endfunction

    // Counter width able to hold steps-1 (at least one bit)
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/sub_digit_slice.sv
// One DIGIT_W-wide subtract slice: res = a + ~b + cin, cout is the slice carry.
module sub_digit_slice #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] res,
    output logic               cout
);

    logic [DIGIT_W:0] sum;

    // Carry-in of 1 means "no borrow pending"; the top bit is the carry out
    assign sum         = {1'b0, a} + {1'b0, ~b} + {{DIGIT_W{1'b0}}, cin};
    assign {cout, res} = sum;

endmodule

// File: rtl/sub_32_bit_serial.sv
// Digit-serial subtractor: diff = input1 - input2 - borrowin, DIGIT_W bits per
// clock, LSB first, with a start/done handshake around a single slice.
module sub_32_bit_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             borrowin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowout,
    output logic             overflow
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT_W);
    localparam int CW    = cnt_width(STEPS);
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SH    = $clog2(DIGIT_W);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, diff_q;
    logic               borrow_q;
    logic [CW-1:0]      cnt_q;
    logic               borrowout_q, overflow_q;

    logic [IW-1:0]      off;
    logic [DIGIT_W-1:0] a_dig, b_dig, dig_res;
    logic               dig_cout;
    logic               last_step;

    // Bit offset of the digit being processed this cycle
    if (STEPS == 1) begin : g_single
        assign off = '0;
    end else begin : g_multi
        assign off = IW'(cnt_q) << SH;
    end

    assign a_dig     = a_q[off +: DIGIT_W];
    assign b_dig     = b_q[off +: DIGIT_W];
    assign last_step = (cnt_q == LAST);

    sub_digit_slice #(
        .DIGIT_W (DIGIT_W)
    ) u_slice (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (~borrow_q),
        .res  (dig_res),
        .cout (dig_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only matters in IDLE, DONE always lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, one digit per RUN cycle, flags on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            borrowout_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q         <= input1;
                        b_q         <= input2;
                        borrow_q    <= borrowin;
                        diff_q      <= '0;
                        cnt_q       <= '0;
                        borrowout_q <= 1'b0;
                        overflow_q  <= 1'b0;
                    end
                end
                RUN: begin
                    diff_q[off +: DIGIT_W] <= dig_res;
                    borrow_q               <= ~dig_cout;
                    cnt_q                  <= cnt_q + CW'(1);
                    if (last_step) begin
                        // The final digit holds the result sign bit
                        borrowout_q <= ~dig_cout;
                        overflow_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                       (dig_res[DIGIT_W-1] ^ a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign diff      = diff_q;
    assign borrowout = borrowout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sub_32_bit_serial.sv
// Directed bench: three digit widths share the same stimulus; results and
// done latency are compared against hand-computed values.
module tb_sub_32_bit_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] input1, input2;
    logic        borrowin;

    logic        busy1, done1, bo1, ov1;
    logic [31:0] diff1;
    logic        busy4, done4, bo4, ov4;
    logic [31:0] diff4;
    logic        busy32, done32, bo32, ov32;
    logic [31:0] diff32;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sub_32_bit_serial #(.WIDTH(32), .DIGIT_W(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .input1(input1), .input2(input2),
        .borrowin(borrowin), .busy(busy1), .done(done1), .diff(diff1),
        .borrowout(bo1), .overflow(ov1)
    );
    sub_32_bit_serial #(.WIDTH(32), .DIGIT_W(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .input1(input1), .input2(input2),
        .borrowin(borrowin), .busy(busy4), .done(done4), .diff(diff4),
        .borrowout(bo4), .overflow(ov4)
    );
    sub_32_bit_serial #(.WIDTH(32), .DIGIT_W(32)) u_d32 (
        .clk(clk), .rst_n(rst_n), .start(start), .input1(input1), .input2(input2),
        .borrowin(borrowin), .busy(busy32), .done(done32), .diff(diff32),
        .borrowout(bo32), .overflow(ov32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one request, then watch 60 cycles; optionally inject a start during RUN
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input int inj_at, output int lat1, output int lat4,
                          output int lat32, output int pulses1);
        @(negedge clk);
        input1 = a; input2 = b; borrowin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat1 = -1; lat4 = -1; lat32 = -1; pulses1 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("busy_run", {63'd0, busy1}, 64'd1);
            if (k == inj_at) begin
                start = 1'b1; input1 = 32'hFFFF_FFFF; input2 = 32'h0; borrowin = 1'b0;
            end
            if (k == inj_at + 1) start = 1'b0;
            if (done1) begin pulses1++; if (lat1 < 0) lat1 = k; end
            if (done4 && lat4 < 0) lat4 = k;
            if (done32 && lat32 < 0) lat32 = k;
        end
    endtask

    // Single-digit-width result check for one vector
    task automatic vec1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic [31:0] ed, input logic eb, input logic eo);
        int l1, l4, l32, p1;
        run_op(a, b, bin, -10, l1, l4, l32, p1);
        chk({tag, "_diff"}, {32'd0, diff1}, {32'd0, ed});
        chk({tag, "_bo"}, {63'd0, bo1}, {63'd0, eb});
        chk({tag, "_ov"}, {63'd0, ov1}, {63'd0, eo});
        chk({tag, "_lat"}, 64'(l1), 64'd32);
        chk({tag, "_pulses"}, 64'(p1), 64'd1);
    endtask

    initial begin
        int l1, l4, l32, p1;
        rst_n = 1'b0; start = 1'b0; input1 = '0; input2 = '0; borrowin = 1'b0;
        #12;
        chk("rst_busy", {63'd0, busy1}, 64'd0);
        chk("rst_done", {63'd0, done1}, 64'd0);
        chk("rst_diff", {32'd0, diff1}, 64'd0);
        chk("rst_bo", {63'd0, bo1}, 64'd0);
        chk("rst_ov", {63'd0, ov1}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        vec1("5m3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        vec1("0m1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        vec1("min_m1", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        vec1("0m0b1", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        vec1("max_mneg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);

        // Same vector on all three digit widths
        run_op(32'd10, 32'd3, 1'b1, -10, l1, l4, l32, p1);
        chk("dw1_diff", {32'd0, diff1}, 64'd6);
        chk("dw4_diff", {32'd0, diff4}, 64'd6);
        chk("dw32_diff", {32'd0, diff32}, 64'd6);
        chk("dw4_bo", {63'd0, bo4}, 64'd0);
        chk("dw32_ov", {63'd0, ov32}, 64'd0);
        chk("dw1_lat", 64'(l1), 64'd32);
        chk("dw4_lat", 64'(l4), 64'd8);
        chk("dw32_lat", 64'(l32), 64'd1);

        // Start during RUN with new operands must be ignored
        run_op(32'd10, 32'd3, 1'b0, 5, l1, l4, l32, p1);
        chk("ign_diff", {32'd0, diff1}, 64'd7);
        chk("ign_bo", {63'd0, bo1}, 64'd0);
        chk("ign_pulses", 64'(p1), 64'd1);
        chk("ign_busy", {63'd0, busy1}, 64'd0);

        // Reset in the middle of a single-bit-digit operation
        @(negedge clk);
        input1 = 32'hFFFF_FFFF; input2 = 32'h0; borrowin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy1}, 64'd0);
        chk("mid_rst_diff", {32'd0, diff1}, 64'd0);
        chk("mid_rst_done", {63'd0, done1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p1 = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done1) p1++;
        end
        chk("mid_rst_nodone", 64'(p1), 64'd0);
        vec1("post_rst", 32'd100, 32'd99, 1'b0, 32'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
